// File: rtl/mazesolver_sysid_checker_if.sv
// ---------------------------------------------------------------------------
// mazesolver_sysid_checker_if
//   Avalon-MM read-only link between the sysid checker (master) and the
//   system-ID slave. Carries only what a single-outstanding read needs.
//
//   address        master -> slave  word address (0 = ID, 1 = timestamp)
//   read           master -> slave  read strobe
//   waitrequest    slave -> master  slave stall, holds the request
//   readdatavalid  slave -> master  readdata qualifier
//   readdata       slave -> master  32-bit read data
// ---------------------------------------------------------------------------
interface mazesolver_sysid_checker_if;

  logic        address;
  logic        read;
  logic        waitrequest;
  logic        readdatavalid;
  logic [31:0] readdata;

  modport master (
    output address,
    output read,
    input  waitrequest,
    input  readdatavalid,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    output waitrequest,
    output readdatavalid,
    output readdata
  );

endinterface

// File: rtl/mazesolver_sysid_checker.sv
// ---------------------------------------------------------------------------
// mazesolver_sysid_checker
//   Boot-time sanity check of the loaded FPGA image: reads the system ID
//   (word 0) and build timestamp (word 1) from the sysid slave over
//   Avalon-MM, compares both against expected values and reports the result.
//   Each word has a per-attempt cycle budget and a bounded number of retries.
//
// Ports
//   clock, reset_n  system clock, asynchronous active-low reset
//   start           single-cycle request to run a check (ignored while busy)
//   avm             Avalon-MM read master (mazesolver_sysid_checker_if.master)
//   busy            check in progress
//   done            result valid, level held until the next start
//   id_ok, ts_ok    captured words matched the expected values
//   timeout         a word exhausted its retries
//   id_value        captured ID word
//   ts_value        captured timestamp word
//
// Build option
//   SYSID_CHECK_AUTOSTART_EN  when defined, a one-shot issues an implicit
//                             start on the first clock after reset release.
// ---------------------------------------------------------------------------
module mazesolver_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1448544260,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              start,
  mazesolver_sysid_checker_if.master        avm,
  output logic                              busy,
  output logic                              done,
  output logic                              id_ok,
  output logic                              ts_ok,
  output logic                              timeout,
  output logic [31:0]                       id_value,
  output logic [31:0]                       ts_value
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned RTY_W  = 3;

  // Counter value on which an attempt expires; the budget is TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE,
    REQ_ID,
    WAIT_ID,
    REQ_TS,
    WAIT_TS,
    CHECK,
    DONE
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_d;
  logic [RTY_W-1:0]   retry;
  logic [RTY_W-1:0]   retry_d;
  // High for the single idle cycle spent in REQ_x before a retried request.
  logic               gap;
  logic               gap_d;

  logic               read_q;
  logic               read_d;
  logic               addr_q;
  logic               addr_d;

  logic               busy_d;
  logic               done_d;
  logic               id_ok_d;
  logic               ts_ok_d;
  logic               timeout_d;
  logic [DATA_W-1:0]  id_value_d;
  logic [DATA_W-1:0]  ts_value_d;

  logic               start_req;
  logic               in_xfer;
  logic               data_hit;
  logic               expire;

  // Implicit start source
`ifdef SYSID_CHECK_AUTOSTART_EN
  logic auto_pend;

  // One-shot: set by reset, consumed on the first clock after release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      auto_pend <= 1'b1;
    end else begin
      auto_pend <= 1'b0;
    end
  end

  assign start_req = start | auto_pend;
`else
  assign start_req = start;
`endif

  // States in which busy is reported.
  function automatic logic is_busy(input state_t s);
    return (s != IDLE) && (s != DONE);
  endfunction

  assign in_xfer  = (state == REQ_ID) || (state == WAIT_ID) ||
                    (state == REQ_TS) || (state == WAIT_TS);
  assign data_hit = ((state == WAIT_ID) || (state == WAIT_TS)) && avm.readdatavalid;
  assign expire   = in_xfer && (cnt == CNT_LAST);

  // Next-state and next-output logic
  always_comb begin
    state_next = state;
    cnt_d      = cnt;
    retry_d    = retry;
    gap_d      = 1'b0;
    id_ok_d    = id_ok;
    ts_ok_d    = ts_ok;
    timeout_d  = timeout;
    id_value_d = id_value;
    ts_value_d = ts_value;
    addr_d     = addr_q;

    unique case (state)
      IDLE, DONE: begin
        if (start_req) begin
          state_next = REQ_ID;
          cnt_d      = '0;
          retry_d    = '0;
          id_ok_d    = 1'b0;
          ts_ok_d    = 1'b0;
          timeout_d  = 1'b0;
        end
      end

      REQ_ID, REQ_TS: begin
        cnt_d = cnt + CNT_W'(1);
        // No acceptance during the retry gap: read is low that cycle.
        if (!gap && !avm.waitrequest) begin
          state_next = (state == REQ_ID) ? WAIT_ID : WAIT_TS;
        end
      end

      WAIT_ID: begin
        cnt_d = cnt + CNT_W'(1);
        if (avm.readdatavalid) begin
          id_value_d = avm.readdata;
          cnt_d      = '0;
          retry_d    = '0;
          state_next = REQ_TS;
        end
      end

      WAIT_TS: begin
        cnt_d = cnt + CNT_W'(1);
        if (avm.readdatavalid) begin
          ts_value_d = avm.readdata;
          cnt_d      = '0;
          retry_d    = '0;
          state_next = CHECK;
        end
      end

      CHECK: begin
        id_ok_d    = (id_value == EXPECTED_ID);
        ts_ok_d    = (ts_value == EXPECTED_TIMESTAMP);
        state_next = DONE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Attempt budget exhausted. Data on the expiring cycle wins; an
    // acceptance on the expiring cycle of REQ_x does not.
    if (expire && !data_hit) begin
      cnt_d = '0;
      if (retry < RTY_MAX) begin
        retry_d    = retry + RTY_W'(1);
        gap_d      = 1'b1;
        state_next = ((state == REQ_ID) || (state == WAIT_ID)) ? REQ_ID : REQ_TS;
      end else begin
        timeout_d  = 1'b1;
        id_ok_d    = 1'b0;
        ts_ok_d    = 1'b0;
        state_next = DONE;
      end
    end

    if (state_next == REQ_ID) begin
      addr_d = 1'b0;
    end else if (state_next == REQ_TS) begin
      addr_d = 1'b1;
    end

    read_d = ((state_next == REQ_ID) || (state_next == REQ_TS)) && !gap_d;
    // Busy stays high until done rises so the two never both read low
    // between a start and its result.
    busy_d = is_busy(state_next) || is_busy(state);
    done_d = (state == DONE) && (state_next == DONE);
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      retry    <= '0;
      gap      <= 1'b0;
      read_q   <= 1'b0;
      addr_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_d;
      retry    <= retry_d;
      gap      <= gap_d;
      read_q   <= read_d;
      addr_q   <= addr_d;
      busy     <= busy_d;
      done     <= done_d;
      id_ok    <= id_ok_d;
      ts_ok    <= ts_ok_d;
      timeout  <= timeout_d;
      id_value <= id_value_d;
      ts_value <= ts_value_d;
    end
  end

  assign avm.read    = read_q;
  assign avm.address = addr_q;

endmodule

// File: tb/tb_mazesolver_sysid_checker.sv
// ---------------------------------------------------------------------------
// tb_mazesolver_sysid_checker
//   Directed bench with a queue-based scoreboard. Each start pushes the
//   expected result; a monitor pops and compares on every rising done.
//   A behavioural sysid slave supplies configurable stall, data and drop.
// ---------------------------------------------------------------------------
module tb_mazesolver_sysid_checker;

  localparam int unsigned TO_CYC  = 8;
  localparam int unsigned MAX_RTY = 2;
  localparam logic [31:0] EXP_ID  = 32'd0;
  localparam logic [31:0] EXP_TS  = 32'd1448544260;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  always #5 clock = ~clock;

  mazesolver_sysid_checker_if avm ();

  mazesolver_sysid_checker #(
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .TIMEOUT_CYCLES     (TO_CYC),
    .MAX_RETRIES        (MAX_RTY)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .avm      (avm),
    .busy     (busy),
    .done     (done),
    .id_ok    (id_ok),
    .ts_ok    (ts_ok),
    .timeout  (timeout),
    .id_value (id_value),
    .ts_value (ts_value)
  );

  // Scoreboard entry
  typedef struct {
    logic        id_ok;
    logic        ts_ok;
    logic        to;
    logic [31:0] idv;
    logic [31:0] tsv;
    int          lat;
    int          sc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Sysid slave model: stall for 'stall' cycles per read, 1-cycle latency,
  // optionally never answer timestamp reads.
  int          stall    = 0;
  logic        drop_ts  = 1'b0;
  logic [31:0] slave_id = EXP_ID;
  logic [31:0] slave_ts = EXP_TS;
  int          wcnt;
  logic        pend;
  logic [31:0] pdata;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wcnt  <= 0;
      pend  <= 1'b0;
      pdata <= '0;
    end else begin
      pend <= 1'b0;
      if (avm.read) begin
        if (avm.waitrequest) begin
          wcnt <= wcnt + 1;
        end else begin
          wcnt <= 0;
          if (!(drop_ts && avm.address)) begin
            pend  <= 1'b1;
            pdata <= avm.address ? slave_ts : slave_id;
          end
        end
      end
    end
  end

  always_comb avm.waitrequest = avm.read && (wcnt < stall);
  assign avm.readdatavalid = pend;
  assign avm.readdata      = pdata;

  // Monitor: result scoreboard, request stability, timestamp attempt count
  logic done_prev = 1'b0;
  logic read_prev = 1'b0;
  logic wr_prev   = 1'b0;
  logic addr_prev = 1'b0;
  int   ts_reads  = 0;
  int   done_cnt  = 0;

  always @(negedge clock) begin
    if (done && !done_prev) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending check");
      end else begin
        mon_e = sb_q.pop_front();
        chk("id_ok",    32'(id_ok),   32'(mon_e.id_ok));
        chk("ts_ok",    32'(ts_ok),   32'(mon_e.ts_ok));
        chk("timeout",  32'(timeout), 32'(mon_e.to));
        chk("id_value", id_value,     mon_e.idv);
        chk("ts_value", ts_value,     mon_e.tsv);
        chk("latency",  32'(cyc - mon_e.sc - 1), 32'(mon_e.lat));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
    if (read_prev && wr_prev) begin
      chk("read_held", 32'(avm.read),    32'd1);
      chk("addr_held", 32'(avm.address), 32'(addr_prev));
    end
    if (avm.read && !read_prev && avm.address) ts_reads++;
    done_prev = done;
    read_prev = avm.read;
    wr_prev   = avm.waitrequest;
    addr_prev = avm.address;
  end

  task automatic push_exp(input logic iok, input logic tok, input logic to,
                          input logic [31:0] idv, input logic [31:0] tsv,
                          input int lat, input int sc);
    exp_t e;
    e.id_ok = iok;
    e.ts_ok = tok;
    e.to    = to;
    e.idv   = idv;
    e.tsv   = tsv;
    e.lat   = lat;
    e.sc    = sc;
    sb_q.push_back(e);
  endtask

  task automatic run_check(input logic iok, input logic tok, input logic to,
                           input logic [31:0] idv, input logic [31:0] tsv, input int lat);
    @(negedge clock);
    push_exp(iok, tok, to, idv, tsv, lat, cyc);
    ts_reads = 0;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL wait_done: no done after %0d cycles, expected done=1", budget);
      sb_q.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},     32'(busy),        32'd0);
    chk({tag, "_done"},     32'(done),        32'd0);
    chk({tag, "_id_ok"},    32'(id_ok),       32'd0);
    chk({tag, "_ts_ok"},    32'(ts_ok),       32'd0);
    chk({tag, "_timeout"},  32'(timeout),     32'd0);
    chk({tag, "_id_value"}, id_value,         32'd0);
    chk({tag, "_ts_value"}, ts_value,         32'd0);
    chk({tag, "_read"},     32'(avm.read),    32'd0);
    chk({tag, "_address"},  32'(avm.address), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset_n = 1'b1;
`ifdef SYSID_CHECK_AUTOSTART_EN
    push_exp(1'b1, 1'b1, 1'b0, slave_id, slave_ts, 6, cyc);
    wait_idle(100);
`else
    repeat (4) @(negedge clock);
    chk("no_autostart_busy", 32'(busy), 32'd0);
    chk("no_autostart_done", 32'(done), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int dc0;
    int n;
    reset_n = 1'b0;
    start   = 1'b0;
    #12;
    check_all_zero("reset");
    release_reset();

    // Clean check against a zero-wait slave
    run_check(1'b1, 1'b1, 1'b0, 32'd0, EXP_TS, 6);
    wait_idle(100);
    repeat (3) @(negedge clock);
    chk("done_held", 32'(done), 32'd1);

    // Wrong system ID
    slave_id = 32'd1;
    run_check(1'b0, 1'b1, 1'b0, 32'd1, EXP_TS, 6);
    wait_idle(100);
    slave_id = EXP_ID;

    // Five stall cycles on each word
    stall = 5;
    run_check(1'b1, 1'b1, 1'b0, 32'd0, EXP_TS, 16);
    wait_idle(100);
    stall = 0;

    // Timestamp never answered: three attempts, then timeout
    drop_ts = 1'b1;
    run_check(1'b0, 1'b0, 1'b1, 32'd0, EXP_TS, 27);
    wait_idle(200);
    chk("ts_attempts", 32'(ts_reads), 32'd3);
    drop_ts = 1'b0;

    // Start pulsed while busy is ignored
    dc0 = done_cnt;
    run_check(1'b1, 1'b1, 1'b0, 32'd0, EXP_TS, 6);
    repeat (2) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_idle(100);
    repeat (10) @(negedge clock);
    chk("single_done", 32'(done_cnt - dc0), 32'd1);

    // Reset during WAIT_TS
    drop_ts  = 1'b1;
    ts_reads = 0;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    n = 0;
    while (!(ts_reads == 1 && !avm.read) && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL reach_wait_ts: no timestamp read after 50 cycles, expected one");
    end
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    sb_q.delete();
    drop_ts = 1'b0;
    repeat (2) @(negedge clock);
    release_reset();
    run_check(1'b1, 1'b1, 1'b0, 32'd0, EXP_TS, 6);
    wait_idle(100);

    repeat (5) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
